uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver. It is the receive end of the serial link that the TDC top drives on its uart_tx pin.
- Used in the top as the command/config input path, and used in benches as a loopback checker for the transmitter.
- Oversamples the asynchronous rx line with the system clock and validates start and stop bits.
- Presents each received byte on a valid/ready handshake with framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 104: system clocks per UART bit. Must be ≥ 8. Default is 12 MHz / 115200.
- SYNC_STAGES, 2: number of flops in the rx input synchronizer. Must be ≥ 2.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: reset, asynchronous, active-low. Assertion is asynchronous; release is synchronous to clk.
- rx, input, 1: serial line. Idles high. Asynchronous to clk.
- rx_data, output, 8: received byte, LSB first on the wire. Stable while rx_valid=1.
- rx_valid, output, 1: byte available. Held until accepted.
- rx_ready, input, 1: consumer accept. The byte is consumed on a cycle where rx_valid & rx_ready.
- frame_err, output, 1: one-cycle pulse. Stop bit sampled low.
- overrun, output, 1: one-cycle pulse. A byte completed while rx_valid was still high.
- busy, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=0):
  - FSM=IDLE, all counters 0, synchronizer flops set to 1.
  - rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Reset mid-frame abandons the frame. No output pulse occurs.
- Synchronizer: rx passes through SYNC_STAGES flops to give rx_s. A further flop gives rx_d for edge detection. All sampling uses rx_s.
- Bit counter: clk_cnt counts 0..CLKS_PER_BIT-1. MID = CLKS_PER_BIT/2 (integer division).
- Majority sample: majority of rx_s at clk_cnt = MID-1, MID, MID+1 within each bit period.
- FSM states and transitions:
  - IDLE:
    - rx_d=1 & rx_s=0 (falling edge) → START, clk_cnt=0.
  - START:
    - At clk_cnt=MID+1, evaluate majority.
    - Majority 0 → DATA, bit_idx=0, clk_cnt restarts so the next bit's MID aligns one bit period later.
    - Majority 1 → false start, return to IDLE. No error flagged.
  - DATA:
    - At each bit's MID+1, the majority value shifts into shift_reg[7] (right shift, LSB first).
    - After bit_idx=7 → STOP.
  - STOP, at MID+1:
    - Majority 1, rx_valid=0 or rx_ready=1 in that cycle:
      - rx_data ← shift_reg and rx_valid=1 from the next cycle. Go to IDLE.
      - A held byte accepted in this same cycle is replaced by the new byte, with no overrun.
    - Majority 1, rx_valid=1 and rx_ready=0:
      - New byte discarded, rx_data unchanged, overrun pulses for 1 cycle. Go to IDLE.
    - Majority 0:
      - frame_err pulses for 1 cycle, byte discarded. Go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering START.
- Early return to IDLE: the FSM returns to IDLE at the stop-bit sample point, not at the end of the stop bit. A start edge arriving 0.5 bit later is captured; back-to-back frames are supported.
- Handshake:
  - rx_valid clears on the cycle after rx_valid & rx_ready.
  - rx_ready is ignored while rx_valid=0.
  - rx_data must not change while rx_valid=1.
- Latency: from the rx falling edge at the pin to rx_valid rising is SYNC_STAGES + 1 + 9*CLKS_PER_BIT + MID + 2 clocks, ±1.
- Glitch rejection: a low pulse shorter than 2 clocks that straddles the start MID window must be rejected as a false start.

Test Plan:
1. Override CLKS_PER_BIT=16. Send 0xA5 at the exact bit rate with rx_ready=1. Expect rx_valid to pulse once with rx_data=0xA5, frame_err=0, overrun=0.
2. With CLKS_PER_BIT=16, rx_ready=0, send 0x3C then 0xC3 back-to-back:
   - Expect rx_data=0x3C with rx_valid held.
   - Expect overrun to pulse once at the second stop sample.
   - Then raise rx_ready; expect rx_valid to drop next cycle and rx_data to remain 0x3C.
3. Drive rx low for 5 clocks, then high (false start). Expect busy to rise then return to 0 by clk_cnt=MID+2, no rx_valid, no frame_err. A following valid 0x00 frame is received correctly.
4. Send 0x55 with the stop bit forced low, holding rx low for 3 more bit periods:
   - Expect frame_err pulse once, no rx_valid.
   - FSM stays busy in BREAK until rx returns high.
   - A subsequent 0xFF frame is received correctly.
5. Send 0x81 with the bit period 3% fast, then another 0x81 with it 3% slow. Both are received as 0x81.
6. Assert rst low mid-data-bit 4 of a frame. Expect all outputs 0 immediately (asynchronous). After release, a clean 0x7E frame is received as 0x7E with no spurious flags.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with majority-voted sampling and a valid/ready byte output.
// Ports: clk, rst (async assert, active-low); rx serial line (idle high, async to clk);
//        rx_data/rx_valid/rx_ready byte handshake; frame_err and overrun one-cycle pulses;
//        busy while a frame (or a held-low break) is being processed.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int MID = CLKS_PER_BIT / 2;
    localparam int CW  = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_d_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   s0_q, s0_d, s1_q, s1_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   rx_s, at_smp, maj;
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign at_smp    = cnt_q == CW'(MID + 1);
    // Vote over the samples taken at MID-1, MID and the live MID+1 sample.
    assign maj       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = state_q != IDLE;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        data_d  = data_q;
        valid_d = valid_q & ~rx_ready;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        // The bit counter free-runs modulo CLKS_PER_BIT once a start edge is seen,
        // so each following sample point lands exactly one bit period later.
        if (state_q == START || state_q == DATA || state_q == STOP) begin
            cnt_d = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CW'(MID - 1)) s0_d = rx_s;
            if (cnt_q == CW'(MID)) s1_d = rx_s;
        end
        unique case (state_q)
            IDLE: if (rx_d_q && !rx_s) begin
                state_d = START;
                cnt_d   = '0;
            end
            START: if (at_smp) begin
                state_d = maj ? IDLE : DATA;
                idx_d   = '0;
            end
            DATA: if (at_smp) begin
                shift_d = {maj, shift_q[7:1]};
                idx_d   = idx_q + 1'b1;
                if (idx_q == 3'd7) state_d = STOP;
            end
            STOP: if (at_smp) begin
                state_d = maj ? IDLE : BREAK;
                ferr_d  = !maj;
                ovr_d   = maj && valid_q && !rx_ready;
                if (maj && (!valid_q || rx_ready)) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= '1;
            rx_d_q  <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            rx_d_q  <= rx_s;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int BT  = CPB * 10;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    int         checks = 0;
    int         errors = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         acc_cnt = 0;
    logic [7:0] exp_q[$];
    logic       pv = 1'b0;
    logic [7:0] pd = 8'h00;
    logic [7:0] e;
    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask
    task automatic send(input logic [7:0] d, input logic stop, input int bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = stop;
        #(bt);
    endtask
    task automatic wait_clks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && pv) begin
                checks++;
                if (rx_data !== pd) begin
                    errors++;
                    $display("FAIL data_stable actual=%0h required=%0h", rx_data, pd);
                end
            end
            if (rx_valid && rx_ready) begin
                checks++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rx_data !== e) begin
                        errors++;
                        $display("FAIL byte actual=%0h required=%0h", rx_data, e);
                    end
                end
                pv = 1'b0;
            end else begin
                pv = rx_valid;
                pd = rx_data;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end
    initial begin
        wait_clks(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {frame_err, overrun}, 0);
        rst = 1'b1;
        wait_clks(5);
        // 1: single byte with the consumer ready
        exp_q.push_back(8'hA5);
        @(posedge clk); #1;
        send(8'hA5, 1'b1, BT);
        wait_clks(4);
        chk("t1_accepts", acc_cnt, 1);
        chk("t1_flags", fe_cnt + ov_cnt, 0);
        // 2: back-to-back bytes with the consumer stalled
        rx_ready = 1'b0;
        exp_q.push_back(8'h3C);
        @(posedge clk); #1;
        send(8'h3C, 1'b1, BT);
        send(8'hC3, 1'b1, BT);
        wait_clks(3);
        chk("t2_overrun", ov_cnt, 1);
        chk("t2_valid_held", rx_valid, 1);
        chk("t2_data_held", rx_data, 8'h3C);
        @(posedge clk); #2;
        rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_valid_drop", rx_valid, 0);
        chk("t2_data_keep", rx_data, 8'h3C);
        chk("t2_accepts", acc_cnt, 2);
        // 3: false start, then an all-zero byte
        @(posedge clk); #1;
        rx = 1'b0;
        wait_clks(4);
        chk("t3_busy_rise", busy, 1);
        @(posedge clk); #1;
        rx = 1'b1;
        wait_clks(12);
        chk("t3_busy_fall", busy, 0);
        chk("t3_no_byte", acc_cnt, 2);
        chk("t3_no_ferr", fe_cnt, 0);
        exp_q.push_back(8'h00);
        @(posedge clk); #1;
        send(8'h00, 1'b1, BT);
        wait_clks(4);
        chk("t3_accepts", acc_cnt, 3);
        // 4: framing error followed by a held-low break
        @(posedge clk); #1;
        send(8'h55, 1'b0, BT);
        #(3 * BT);
        @(negedge clk);
        chk("t4_ferr", fe_cnt, 1);
        chk("t4_break_busy", busy, 1);
        chk("t4_no_byte", acc_cnt, 3);
        rx = 1'b1;
        wait_clks(6);
        chk("t4_idle", busy, 0);
        exp_q.push_back(8'hFF);
        @(posedge clk); #1;
        send(8'hFF, 1'b1, BT);
        wait_clks(4);
        chk("t4_accepts", acc_cnt, 4);
        // 5: bit period about 3% fast, then about 3% slow
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h81);
        @(posedge clk); #1;
        send(8'h81, 1'b1, BT - 5);
        #(BT);
        send(8'h81, 1'b1, BT + 5);
        wait_clks(4);
        chk("t5_accepts", acc_cnt, 6);
        chk("t5_flags", fe_cnt + ov_cnt, 2);
        // 6: asynchronous reset mid-frame while a byte is held
        rx_ready = 1'b0;
        @(posedge clk); #1;
        send(8'h96, 1'b1, BT);
        wait_clks(3);
        chk("t6_held", {rx_valid, rx_data}, {1'b1, 8'h96});
        @(posedge clk); #1;
        rx = 1'b0;
        #(BT);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            #(BT);
        end
        rx = 1'b1;
        #(BT / 2);
        @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("t6_async_outs", {rx_valid, rx_data, frame_err, overrun, busy}, 0);
        exp_q.delete();
        wait_clks(3);
        rst = 1'b1;
        rx_ready = 1'b1;
        wait_clks(3);
        exp_q.push_back(8'h7E);
        @(posedge clk); #1;
        send(8'h7E, 1'b1, BT);
        wait_clks(4);
        chk("t6_accepts", acc_cnt, 7);
        chk("t6_flags", fe_cnt + ov_cnt, 2);
        wait_clks(10);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
